// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the DMA engine.
//   - FSM state encoding (IDLE, RD_REQ, RD_WAIT, WR_REQ)
//   - ADDR_INC: byte stride between consecutive 32-bit words
//   - word_align(): clears the byte-offset bits of an address
package dma_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] WR_REQ  = 2'd3;

    localparam logic [31:0] ADDR_INC = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dma_timeout_cnt.sv
// dma_timeout_cnt: no-progress watchdog for the DMA engine.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en_i        - engine is in an active (non-IDLE) state this cycle
//   clr_i       - engine makes progress (takes a handshake) this cycle
//   expired_o   - this is the TIMEOUT_CYCLES-th consecutive active cycle without progress
module dma_timeout_cnt
    import dma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of completed no-progress cycles, so the current
    // cycle is the (cnt_q+1)-th one; the abort fires on the edge ending it.
    always_comb begin
        expired_o = en_i && !clr_i && (cnt_q == Limit);
        cnt_d     = cnt_q + 1'b1;
        if (!en_i || clr_i || expired_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dma_engine.sv
// dma_engine: single-channel word-by-word memory copy engine.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   dma_start, size_dtrans,
//   src_reg, dst_reg            - start pulse and transfer parameters
//   dma_done, dma_err           - completion / timeout-abort status levels
//   rd_req, rd_addr, rd_gnt,
//   rd_valid, rd_data           - read request channel and returned data
//   wr_req, wr_addr, wr_data,
//   wr_gnt                      - write request channel
// All request-side outputs come straight from flops.
module dma_engine
    import dma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_start,
    input  logic [15:0] size_dtrans,
    input  logic [31:0] src_reg,
    input  logic [31:0] dst_reg,
    output logic        dma_done,
    output logic        dma_err,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_gnt,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_gnt
);

    logic [1:0]  state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic        rd_req_q, rd_req_d;
    logic        wr_req_q, wr_req_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        active;
    logic        progress;
    logic        timeout;

    assign active   = (state_q != IDLE);
    assign progress = ((state_q == RD_REQ)  && rd_gnt)   ||
                      ((state_q == RD_WAIT) && rd_valid) ||
                      ((state_q == WR_REQ)  && wr_gnt);

    dma_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (active),
        .clr_i    (progress),
        .expired_o(timeout)
    );

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        rd_req_d = rd_req_q;
        wr_req_d = wr_req_q;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (dma_start) begin
                    src_d  = word_align(src_reg);
                    dst_d  = word_align(dst_reg);
                    cnt_d  = size_dtrans;
                    err_d  = 1'b0;
                    if (size_dtrans == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d   = 1'b0;
                        state_d  = RD_REQ;
                        rd_req_d = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (rd_gnt) begin
                    src_d    = src_q + ADDR_INC;
                    rd_req_d = 1'b0;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_valid) begin
                    buf_d    = rd_data;
                    wr_req_d = 1'b1;
                    state_d  = WR_REQ;
                end
            end
            WR_REQ: begin
                if (wr_gnt) begin
                    dst_d    = dst_q + ADDR_INC;
                    cnt_d    = cnt_q - 16'd1;
                    wr_req_d = 1'b0;
                    if (cnt_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rd_req_d = 1'b1;
                        state_d  = RD_REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout only asserts when no handshake happened this cycle, so it
        // never competes with a progress transition above.
        if (timeout) begin
            state_d  = IDLE;
            rd_req_d = 1'b0;
            wr_req_d = 1'b0;
            done_d   = 1'b1;
            err_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rd_req   = rd_req_q;
    assign rd_addr  = src_q;
    assign wr_req   = wr_req_q;
    assign wr_addr  = dst_q;
    assign wr_data  = buf_q;
    assign dma_done = done_q;
    assign dma_err  = err_q;

endmodule
